// File: rtl/rom_map_pkg.sv
// rtl/rom_map_pkg.sv - external ROM address map, strobe indices and loader states
package rom_map_pkg;

    // Each window matches when (addr & mask) == base; windows are disjoint.
    localparam logic [16:0] BG_BASE      = 17'h0A000;
    localparam logic [16:0] BG_MASK      = 17'h1F000;
    localparam logic [16:0] CPU2_BASE    = 17'h08000;
    localparam logic [16:0] CPU2_MASK    = 17'h1E000;
    localparam logic [16:0] PALROM1_BASE = 17'h0B400;
    localparam logic [16:0] PALROM1_MASK = 17'h1FF00;
    localparam logic [16:0] PALROM3_BASE = 17'h0B000;
    localparam logic [16:0] PALROM3_MASK = 17'h1FC00;
    localparam logic [16:0] CLUT_BASE    = 17'h0B600;
    localparam logic [16:0] CLUT_MASK    = 17'h1FFE0;
    localparam logic [16:0] WAVROM_BASE  = 17'h0B500;
    localparam logic [16:0] WAVROM_MASK  = 17'h1FF00;
    localparam logic [16:0] SPR1_BASE    = 17'h10000;
    localparam logic [16:0] SPR1_MASK    = 17'h1C000;
    localparam logic [16:0] SPR2_BASE    = 17'h14000;
    localparam logic [16:0] SPR2_MASK    = 17'h1C000;

    localparam int DL_WE_BG      = 0;
    localparam int DL_WE_CPU2    = 1;
    localparam int DL_WE_PALROM1 = 2;
    localparam int DL_WE_PALROM3 = 3;
    localparam int DL_WE_CLUT    = 4;
    localparam int DL_WE_WAVROM  = 5;
    localparam int DL_WE_SPR1    = 6;
    localparam int DL_WE_SPR2    = 7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_CAPT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic in_window(input logic [16:0] addr,
                                       input logic [16:0] base,
                                       input logic [16:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - one-hot on-chip ROM strobe decode of a 17-bit address
module rom_region_decode
    import rom_map_pkg::*;
(
    input  logic [16:0] addr,
    output logic [7:0]  we
);

    always_comb begin
        we                = '0;
        we[DL_WE_BG]      = in_window(addr, BG_BASE, BG_MASK);
        we[DL_WE_CPU2]    = in_window(addr, CPU2_BASE, CPU2_MASK);
        we[DL_WE_PALROM1] = in_window(addr, PALROM1_BASE, PALROM1_MASK);
        we[DL_WE_PALROM3] = in_window(addr, PALROM3_BASE, PALROM3_MASK);
        we[DL_WE_CLUT]    = in_window(addr, CLUT_BASE, CLUT_MASK);
        we[DL_WE_WAVROM]  = in_window(addr, WAVROM_BASE, WAVROM_MASK);
        we[DL_WE_SPR1]    = in_window(addr, SPR1_BASE, SPR1_MASK);
        we[DL_WE_SPR2]    = in_window(addr, SPR2_BASE, SPR2_MASK);
    end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - boot-time external ROM sweep into on-chip ROM images
module rom_loader
    import rom_map_pkg::*;
#(
    parameter logic [3:0]  ROM_WAIT    = 4'd2,
    parameter logic [16:0] LAST_ADDR   = 17'h1FFFF,
    parameter logic [7:0]  RELEASE_DLY = 8'd16
) (
    input  logic        clk_6144,
    input  logic        rst,
    input  logic [7:0]  rom_d,
    input  logic [14:0] rom_ra,
    output logic [18:0] rom_a,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic [7:0]  dl_we,
    output logic        romtrans_done,
    output logic        n_main_reset,
    output logic        n_sub_reset,
    output logic [15:0] checksum
);

    logic [2:0]  state;
    logic [16:0] cnt;
    logic [3:0]  wait_cnt;
    logic [7:0]  rel_cnt;
    logic [18:0] load_a;
    logic [7:0]  region_we;

    rom_region_decode u_decode (
        .addr (cnt),
        .we   (region_we)
    );

    always_ff @(posedge clk_6144) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            wait_cnt      <= '0;
            rel_cnt       <= '0;
            load_a        <= '0;
            dl_addr       <= '0;
            dl_data       <= '0;
            dl_we         <= '0;
            romtrans_done <= 1'b0;
            n_main_reset  <= 1'b0;
            n_sub_reset   <= 1'b0;
            checksum      <= '0;
        end else begin
            dl_we <= '0;
            case (state)
                ST_IDLE: state <= ST_ADDR;
                ST_ADDR: begin
                    load_a   <= {2'b00, cnt};
                    wait_cnt <= ROM_WAIT;
                    state    <= (ROM_WAIT == 4'd0) ? ST_CAPT : ST_WAIT;
                end
                // WAIT lasts exactly ROM_WAIT cycles, giving ROM_WAIT+2 cycles per byte
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1)
                        state <= ST_CAPT;
                end
                ST_CAPT: begin
                    dl_data  <= rom_d;
                    dl_addr  <= cnt;
                    dl_we    <= region_we;
                    checksum <= checksum + {8'h00, rom_d};
                    if (cnt == LAST_ADDR) begin
                        state         <= ST_DONE;
                        romtrans_done <= 1'b1;
                    end else begin
                        cnt   <= cnt + 17'd1;
                        state <= ST_ADDR;
                    end
                end
                ST_DONE: begin
                    if (!n_main_reset) begin
                        rel_cnt <= rel_cnt + 8'd1;
                        if (rel_cnt == RELEASE_DLY - 8'd1) begin
                            n_main_reset <= 1'b1;
                            n_sub_reset  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The main CPU owns the bus combinationally from the cycle done rises.
    assign rom_a = romtrans_done ? {4'b0000, rom_ra} : load_a;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed self-checking bench for rom_loader
module tb_rom_loader;

    logic        clk_6144;
    logic        rst0, rst1;
    logic [14:0] rom_ra;
    logic [7:0]  rom_d0, rom_d1;
    logic [18:0] rom_a0, rom_a1;
    logic [16:0] dl_addr0, dl_addr1;
    logic [7:0]  dl_data0, dl_data1;
    logic [7:0]  dl_we0, dl_we1;
    logic        done0, done1;
    logic        n_main0, n_main1, n_sub0, n_sub1;
    logic [15:0] checksum0, checksum1;
    logic [16:0] dec_addr;
    logic [7:0]  dec_we;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] rom_byte(input logic [18:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    assign rom_d0 = rom_byte(rom_a0);
    assign rom_d1 = rom_byte(rom_a1);

    rom_loader #(.ROM_WAIT(4'd2), .LAST_ADDR(17'h0003F), .RELEASE_DLY(8'd16)) u_dut0 (
        .clk_6144      (clk_6144),
        .rst           (rst0),
        .rom_d         (rom_d0),
        .rom_ra        (rom_ra),
        .rom_a         (rom_a0),
        .dl_addr       (dl_addr0),
        .dl_data       (dl_data0),
        .dl_we         (dl_we0),
        .romtrans_done (done0),
        .n_main_reset  (n_main0),
        .n_sub_reset   (n_sub0),
        .checksum      (checksum0)
    );

    rom_loader #(.ROM_WAIT(4'd0), .LAST_ADDR(17'h003FF), .RELEASE_DLY(8'd1)) u_dut1 (
        .clk_6144      (clk_6144),
        .rst           (rst1),
        .rom_d         (rom_d1),
        .rom_ra        (rom_ra),
        .rom_a         (rom_a1),
        .dl_addr       (dl_addr1),
        .dl_data       (dl_data1),
        .dl_we         (dl_we1),
        .romtrans_done (done1),
        .n_main_reset  (n_main1),
        .n_sub_reset   (n_sub1),
        .checksum      (checksum1)
    );

    rom_region_decode u_dec (
        .addr (dec_addr),
        .we   (dec_we)
    );

    initial clk_6144 = 1'b0;
    always #5 clk_6144 = ~clk_6144;

    localparam logic [24:0] DEC_TAB [20] = '{
        {17'h0A005, 8'h01}, {17'h0A000, 8'h01}, {17'h0AFFF, 8'h01}, {17'h08000, 8'h02},
        {17'h09FFF, 8'h02}, {17'h07FFF, 8'h00}, {17'h0B400, 8'h04}, {17'h0B4FF, 8'h04},
        {17'h0B000, 8'h08}, {17'h0B3FF, 8'h08}, {17'h0B600, 8'h10}, {17'h0B61F, 8'h10},
        {17'h0B620, 8'h00}, {17'h0B500, 8'h20}, {17'h0B5FF, 8'h20}, {17'h10000, 8'h40},
        {17'h13FFF, 8'h40}, {17'h14000, 8'h80}, {17'h17FFF, 8'h80}, {17'h18000, 8'h00}
    };

    task automatic step();
        @(posedge clk_6144);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1;
        rst1 = 1'b1;
        rom_ra = 15'h1234;
        dec_addr = '0;
        step();
        checks++;
        if ({rom_a0, dl_addr0, dl_data0, dl_we0} !== 52'h0) begin
            errors++;
            $display("FAIL reset_bus: got rom_a=%h dl_addr=%h dl_data=%h dl_we=%h, expected all 0",
                     rom_a0, dl_addr0, dl_data0, dl_we0);
        end
        checks++;
        if ({done0, n_main0, n_sub0, checksum0} !== 19'h0) begin
            errors++;
            $display("FAIL reset_status: got done=%b n_main=%b n_sub=%b checksum=%h, expected all 0",
                     done0, n_main0, n_sub0, checksum0);
        end
    endtask

    task automatic test_decode();
        logic [24:0] entry;
        for (int i = 0; i < 20; i++) begin
            entry = DEC_TAB[i];
            dec_addr = entry[24:8];
            #1;
            checks++;
            if (dec_we !== entry[7:0]) begin
                errors++;
                $display("FAIL decode_%h: got %h expected %h", dec_addr, dec_we, entry[7:0]);
            end
        end
    endtask

    // Sweep dut0 from reset; returns cycles from reset release to done.
    task automatic sweep0(output int c, input logic check_bytes);
        int k;
        c = 0;
        rst0 = 1'b0;
        while (done0 !== 1'b1 && c < 2000) begin
            step();
            c++;
            if (check_bytes && c >= 5 && c <= 41 && ((c - 5) % 4) == 0) begin
                k = (c - 5) / 4;
                checks++;
                if (dl_addr0 !== 17'(k) || dl_data0 !== rom_byte(19'(k))) begin
                    errors++;
                    $display("FAIL capture_w2_%0d: got addr=%h data=%h expected addr=%h data=%h",
                             k, dl_addr0, dl_data0, 17'(k), rom_byte(19'(k)));
                end
            end
        end
    endtask

    task automatic test_sweep_wait2();
        int c;
        rst0 = 1'b1;
        step();
        sweep0(c, 1'b1);
        checks++;
        if (c !== 257) begin
            errors++;
            $display("FAIL done_cycle_w2: got %0d expected 257", c);
        end
        checks++;
        if (checksum0 !== 16'h07E0) begin
            errors++;
            $display("FAIL checksum_w2: got %h expected 07e0", checksum0);
        end
        checks++;
        if (rom_a0 !== 19'h01234) begin
            errors++;
            $display("FAIL rom_a_handover: got %h expected 01234", rom_a0);
        end
        checks++;
        if (dl_addr0 !== 17'h0003F || dl_data0 !== 8'h3F || dl_we0 !== 8'h00) begin
            errors++;
            $display("FAIL last_byte_w2: got addr=%h data=%h we=%h expected 0003f 3f 00",
                     dl_addr0, dl_data0, dl_we0);
        end
    endtask

    task automatic test_release();
        repeat (15) step();
        checks++;
        if (n_main0 !== 1'b0 || n_sub0 !== 1'b0) begin
            errors++;
            $display("FAIL release_early: got n_main=%b n_sub=%b expected 0 0", n_main0, n_sub0);
        end
        step();
        checks++;
        if (n_main0 !== 1'b1 || n_sub0 !== 1'b1) begin
            errors++;
            $display("FAIL release_at_16: got n_main=%b n_sub=%b expected 1 1", n_main0, n_sub0);
        end
        rom_ra = 15'h7ABC;
        #1;
        checks++;
        if (rom_a0 !== 19'h07ABC) begin
            errors++;
            $display("FAIL rom_a_passthrough: got %h expected 07abc", rom_a0);
        end
        rom_ra = 15'h1234;
    endtask

    task automatic test_rst_after_done();
        int c;
        repeat (83) step();
        rst0 = 1'b1;
        step();
        checks++;
        if ({done0, n_main0, n_sub0} !== 3'b000 || rom_a0 !== 19'h0 || checksum0 !== 16'h0) begin
            errors++;
            $display("FAIL rst_after_done: got done=%b n_main=%b n_sub=%b rom_a=%h checksum=%h expected 0",
                     done0, n_main0, n_sub0, rom_a0, checksum0);
        end
        sweep0(c, 1'b0);
        checks++;
        if (c !== 257 || checksum0 !== 16'h07E0) begin
            errors++;
            $display("FAIL reload: got cycles=%0d checksum=%h expected 257 07e0", c, checksum0);
        end
    endtask

    task automatic test_rst_mid_sweep();
        int c;
        int guard;
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        guard = 0;
        while (rom_a0 !== 19'h00023 && guard < 500) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL mid_sweep_reach: got rom_a=%h expected 00023 within 500 cycles", rom_a0);
        end
        rst0 = 1'b1;
        step();
        checks++;
        if (dl_we0 !== 8'h00 || rom_a0 !== 19'h0 || dl_addr0 !== 17'h0 || checksum0 !== 16'h0) begin
            errors++;
            $display("FAIL mid_sweep_rst: got we=%h rom_a=%h dl_addr=%h checksum=%h expected 0",
                     dl_we0, rom_a0, dl_addr0, checksum0);
        end
        sweep0(c, 1'b1);
        checks++;
        if (c !== 257 || checksum0 !== 16'h07E0) begin
            errors++;
            $display("FAIL mid_sweep_restart: got cycles=%0d checksum=%h expected 257 07e0", c, checksum0);
        end
    endtask

    task automatic test_sweep_wait0();
        int c;
        int k;
        int stray;
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        c = 0;
        stray = 0;
        while (done1 !== 1'b1 && c < 5000) begin
            step();
            c++;
            if (dl_we1 !== 8'h00)
                stray++;
            if (c >= 3 && c <= 61 && ((c - 3) % 2) == 0) begin
                k = (c - 3) / 2;
                checks++;
                if (dl_addr1 !== 17'(k) || dl_data1 !== rom_byte(19'(k))) begin
                    errors++;
                    $display("FAIL capture_w0_%0d: got addr=%h data=%h expected addr=%h data=%h",
                             k, dl_addr1, dl_data1, 17'(k), rom_byte(19'(k)));
                end
            end
        end
        checks++;
        if (c !== 2049) begin
            errors++;
            $display("FAIL done_cycle_w0: got %0d expected 2049", c);
        end
        checks++;
        if (checksum1 !== 16'hFE00) begin
            errors++;
            $display("FAIL checksum_w0: got %h expected fe00", checksum1);
        end
        checks++;
        if (dl_addr1 !== 17'h003FF || dl_data1 !== 8'hFC || stray !== 0) begin
            errors++;
            $display("FAIL last_byte_w0: got addr=%h data=%h stray_we=%0d expected 003ff fc 0",
                     dl_addr1, dl_data1, stray);
        end
        step();
        checks++;
        if (n_main1 !== 1'b1 || n_sub1 !== 1'b1) begin
            errors++;
            $display("FAIL release_dly1: got n_main=%b n_sub=%b expected 1 1", n_main1, n_sub1);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_sweep_wait2();
        test_release();
        test_rst_after_done();
        test_rst_mid_sweep();
        test_sweep_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
